// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module   : mix_columns_seq
// Brief    : Sequential AES MixColumns / InvMixColumns engine. Accepts a
//            32*NB-bit state over valid/ready, transforms one 32-bit column
//            per clock and returns the result over a second valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module mix_columns_seq #(
   parameter int NB     = 4,
   parameter bit INV_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [32*NB-1:0] state_i,
   input  logic             inv_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [32*NB-1:0] state_o,
   output logic             busy
);

   localparam int            CW       = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] LAST_COL = CW'(NB - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t             fsm;
   fsm_t             fsm_nx;
   logic [CW-1:0]    col_cnt;
   logic [32*NB-1:0] captured;
   logic [32*NB-1:0] result;
   logic             inv_flag;
   logic [31:0]      col_in;
   logic [31:0]      col_out;

   // GF(2^8) multiply by x, reduced modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   // Forward column mix: coefficient row {2,3,1,1} rotated per output byte
   function automatic logic [31:0] mix_fwd(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] d [4];
      for (int i = 0; i < 4; i++) begin
         a[i] = c[31-8*i -: 8];
         d[i] = xtime(a[i]);
      end
      return {d[0] ^ d[1] ^ a[1] ^ a[2] ^ a[3],
              a[0] ^ d[1] ^ d[2] ^ a[2] ^ a[3],
              a[0] ^ a[1] ^ d[2] ^ d[3] ^ a[3],
              d[0] ^ a[0] ^ a[1] ^ a[2] ^ d[3]};
   endfunction

   // Inverse column mix: coefficient row {14,11,13,9} rotated per output byte
   function automatic logic [31:0] mix_inv(input logic [31:0] c);
      logic [7:0] a   [4];
      logic [7:0] x2  [4];
      logic [7:0] x4  [4];
      logic [7:0] x8  [4];
      logic [7:0] m9  [4];
      logic [7:0] m11 [4];
      logic [7:0] m13 [4];
      logic [7:0] m14 [4];
      for (int i = 0; i < 4; i++) begin
         a[i]   = c[31-8*i -: 8];
         x2[i]  = xtime(a[i]);
         x4[i]  = xtime(x2[i]);
         x8[i]  = xtime(x4[i]);
         m9[i]  = x8[i] ^ a[i];
         m11[i] = x8[i] ^ x2[i] ^ a[i];
         m13[i] = x8[i] ^ x4[i] ^ a[i];
         m14[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
              m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
              m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
              m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
   endfunction

   // Select the column addressed by the counter from the captured state
   always_comb begin
      col_in = '0;
      for (int c = 0; c < NB; c++) begin
         if (col_cnt == CW'(c)) begin
            col_in = captured[32*(NB-c)-1 -: 32];
         end
      end
   end

   // The inverse datapath only exists when it is enabled
   generate
      if (INV_EN) begin : g_inv
         assign col_out = inv_flag ? mix_inv(col_in) : mix_fwd(col_in);
      end else begin : g_fwd_only
         assign col_out = mix_fwd(col_in);
      end
   endgenerate

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm <= IDLE;
      end else begin
         fsm <= fsm_nx;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      fsm_nx    = fsm;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (fsm)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               fsm_nx = RUN;
            end
         end
         RUN: begin
            if (col_cnt == LAST_COL) begin
               fsm_nx = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               fsm_nx = IDLE;
            end
         end
         default: begin
            fsm_nx = IDLE;
            busy   = 1'b0;
         end
      endcase
   end

   // Capture on acceptance, then write one transformed column per RUN cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt  <= '0;
         captured <= '0;
         result   <= '0;
         inv_flag <= 1'b0;
      end else if (fsm == IDLE && in_valid) begin
         captured <= state_i;
         inv_flag <= inv_i & INV_EN;
         col_cnt  <= '0;
      end else if (fsm == RUN) begin
         for (int c = 0; c < NB; c++) begin
            if (col_cnt == CW'(c)) begin
               result[32*(NB-c)-1 -: 32] <= col_out;
            end
         end
         // Counter parks on the last column; it is cleared on the next acceptance
         if (col_cnt != LAST_COL) begin
            col_cnt <= col_cnt + CW'(1);
         end
      end
   end

   assign state_o = result;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mix_columns_seq
// Brief    : Scoreboard bench for mix_columns_seq (FIPS vectors, reduction,
//            backpressure, reset mid-run, back-to-back).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mix_columns_seq;

   localparam int NB = 4;

   logic         clk       = 1'b0;
   logic         rst       = 1'b1;
   logic         in_valid  = 1'b0;
   logic         in_ready;
   logic [127:0] state_i   = '0;
   logic         inv_i     = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] state_o;
   logic         busy;

   int           n_cmp  = 0;
   int           n_fail = 0;
   logic [127:0] exp_q [$];

   localparam logic [127:0] S_FIPS = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] R_FIPS = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] S_RED  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
   localparam logic [127:0] R_RED  = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

   always #5 clk = ~clk;

   mix_columns_seq #(.NB(NB), .INV_EN(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_i   (state_i),
      .inv_i     (inv_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_o   (state_o),
      .busy      (busy)
   );

   // Reference model: generic shift-and-add GF(2^8) multiply
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] p;
      logic       hi;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1B;
         b  = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_state(input logic [127:0] s, input logic inv);
      logic [7:0]   coef [4];
      logic [127:0] r;
      logic [7:0]   acc;
      if (inv) begin
         coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
      end else begin
         coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
      end
      r = '0;
      for (int c = 0; c < NB; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
               acc = acc ^ gmul(s[127-32*c-8*j -: 8], coef[(j - row + 4) % 4]);
            end
            r[127-32*c-8*row -: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] pop_exp();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a state and wait until it is accepted; expected result is queued
   task automatic send(input logic [127:0] s, input logic inv, input logic [127:0] expv,
                       input bit hold, output bit accepted);
      bit was_ready;
      accepted = 1'b0;
      state_i  = s;
      inv_i    = inv;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !accepted; i++) begin
         was_ready = in_ready;
         tick();
         if (was_ready) accepted = 1'b1;
      end
      if (accepted) exp_q.push_back(expv);
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cycles, output bit seen);
      cycles = 0;
      while (!out_valid && cycles < 50) begin
         tick();
         cycles++;
      end
      seen = out_valid;
   endtask

   // Full operation: returns the observed result and latency, completes the handshake
   task automatic do_op(input logic [127:0] s, input logic inv, input logic [127:0] expv,
                        output logic [127:0] got, output int lat, output bit ok);
      bit acc;
      bit seen;
      send(s, inv, expv, 1'b0, acc);
      wait_out(lat, seen);
      ok  = acc && seen;
      got = state_o;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      out_ready = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_cmp++;
      if (state_o !== 128'h0) begin n_fail++; $display("FAIL reset_state_o got=%h want=0", state_o); end
   endtask

   task automatic test_fwd_fips();
      logic [127:0] got;
      logic [127:0] expv;
      int lat;
      bit ok;
      do_op(S_FIPS, 1'b0, R_FIPS, got, lat, ok);
      expv = pop_exp();
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL fwd_handshake got=timeout want=result"); end
      n_cmp++;
      if (lat !== 4) begin n_fail++; $display("FAIL fwd_latency got=%0d want=4", lat); end
      n_cmp++;
      if (got !== expv) begin n_fail++; $display("FAIL fwd_fips got=%h want=%h", got, expv); end
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL fwd_after_hs got=ov%b ir%b want=ov0 ir1", out_valid, in_ready);
      end
   endtask

   task automatic test_inverse();
      logic [127:0] got;
      logic [127:0] expv;
      bit acc;
      bit seen;
      int lat;
      send(R_FIPS, 1'b1, S_FIPS, 1'b0, acc);
      inv_i = 1'b0;  // must be ignored while running
      wait_out(lat, seen);
      got = state_o;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      expv = pop_exp();
      n_cmp++;
      if (!(acc && seen) || lat !== 4) begin n_fail++; $display("FAIL inv_latency got=%0d want=4", lat); end
      n_cmp++;
      if (got !== expv) begin n_fail++; $display("FAIL inv_fips got=%h want=%h", got, expv); end
   endtask

   task automatic test_reduction();
      logic [127:0] tin  [4];
      logic         tinv [4];
      logic [127:0] texp [4];
      logic [127:0] got;
      logic [127:0] expv;
      int lat;
      bit ok;
      tin[0] = S_RED;  tinv[0] = 1'b0; texp[0] = R_RED;
      tin[1] = R_RED;  tinv[1] = 1'b1; texp[1] = S_RED;
      tin[2] = 128'h00112233_44556677_8899aabb_ccddeeff; tinv[2] = 1'b0;
      texp[2] = ref_state(tin[2], 1'b0);
      tin[3] = texp[2]; tinv[3] = 1'b1; texp[3] = tin[2];
      for (int i = 0; i < 4; i++) begin
         do_op(tin[i], tinv[i], texp[i], got, lat, ok);
         expv = pop_exp();
         n_cmp++;
         if (!ok || got !== expv) begin
            n_fail++; $display("FAIL reduction_%0d got=%h want=%h", i, got, expv);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] first;
      logic [127:0] got;
      logic [127:0] s_b;
      bit acc;
      bit seen;
      bit stable;
      int lat;
      s_b = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
      send(S_FIPS, 1'b0, ref_state(S_FIPS, 1'b0), 1'b1, acc);
      n_cmp++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_run_flags got=busy%b ir%b want=busy1 ir0", busy, in_ready);
      end
      state_i = s_b;
      inv_i   = 1'b1;
      wait_out(lat, seen);
      first  = pop_exp();
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (out_valid !== 1'b1 || state_o !== first || in_ready !== 1'b0) stable = 1'b0;
         tick();
      end
      n_cmp++;
      if (!(acc && seen) || !stable) begin
         n_fail++; $display("FAIL bp_hold got=ov%b so=%h want=ov1 so=%h", out_valid, state_o, first);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL bp_release got=ov%b ir%b busy%b want=ov0 ir1 busy0", out_valid, in_ready, busy);
      end
      exp_q.push_back(ref_state(s_b, 1'b1));
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_accept_next got=busy%b want=busy1", busy); end
      wait_out(lat, seen);
      got = state_o;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      first = pop_exp();
      n_cmp++;
      if (!seen || got !== first) begin n_fail++; $display("FAIL bp_second got=%h want=%h", got, first); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] got;
      logic [127:0] expv;
      bit acc;
      bit spurious;
      int lat;
      bit ok;
      send(S_FIPS, 1'b0, R_FIPS, 1'b0, acc);
      tick();            // first RUN edge done; now in RUN cycle 2
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_flags got=ir%b ov%b busy%b want=ir1 ov0 busy0", in_ready, out_valid, busy);
      end
      n_cmp++;
      if (state_o !== 128'h0) begin n_fail++; $display("FAIL rstmid_state_o got=%h want=0", state_o); end
      spurious = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid !== 1'b0) spurious = 1'b1;
         tick();
      end
      n_cmp++;
      if (spurious) begin n_fail++; $display("FAIL rstmid_no_output got=out_valid want=none"); end
      do_op(R_RED, 1'b1, S_RED, got, lat, ok);
      expv = pop_exp();
      n_cmp++;
      if (!ok || got !== expv) begin n_fail++; $display("FAIL rstmid_after got=%h want=%h", got, expv); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] bs [3];
      logic         bi [3];
      int           acc_cyc [3];
      int           na;
      int           no;
      bit           acc;
      bit           hs;
      bit           extra;
      logic [127:0] expv;
      bs[0] = S_FIPS; bi[0] = 1'b0;
      bs[1] = R_RED;  bi[1] = 1'b1;
      bs[2] = 128'h00112233_44556677_8899aabb_ccddeeff; bi[2] = 1'b0;
      na = 0;
      no = 0;
      state_i   = bs[0];
      inv_i     = bi[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 80 && no < 3; cyc++) begin
         acc = in_valid && in_ready;
         hs  = out_valid && out_ready;
         if (hs) begin
            expv = pop_exp();
            n_cmp++;
            if (state_o !== expv) begin n_fail++; $display("FAIL b2b_result_%0d got=%h want=%h", no, state_o, expv); end
            no++;
         end
         if (acc) begin
            exp_q.push_back(ref_state(bs[na], bi[na]));
            acc_cyc[na] = cyc;
            na++;
         end
         tick();
         if (acc) begin
            if (na < 3) begin
               state_i = bs[na];
               inv_i   = bi[na];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      n_cmp++;
      if (no !== 3 || na !== 3) begin n_fail++; $display("FAIL b2b_count got=%0d/%0d want=3/3", na, no); end
      n_cmp++;
      if (na == 3 && (acc_cyc[1] - acc_cyc[0] !== 6 || acc_cyc[2] - acc_cyc[1] !== 6)) begin
         n_fail++; $display("FAIL b2b_interval got=%0d,%0d want=6,6", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
      extra = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) extra = 1'b1;
         tick();
      end
      out_ready = 1'b0;
      n_cmp++;
      if (extra || exp_q.size() != 0) begin
         n_fail++; $display("FAIL b2b_duplicate got=extra%b q%0d want=extra0 q0", extra, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_fwd_fips();
      test_inverse();
      test_reduction();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
